// File: rtl/tap_tempo_pkg.sv
// tap_tempo_pkg: shared tap-tempo constants, state encoding and tick-count helper.
package tap_tempo_pkg;
  localparam int PULSE_PER_NS_DEF = 5120;
  localparam logic [0:0] s_idle  = 1'b0;
  localparam logic [0:0] s_count = 1'b1;
  function automatic int ns_to_count(input int ns, input int per_ns);
    return ns / per_ns;
  endfunction
endpackage

// File: rtl/tap_period_if.sv
// tap_period_if: time pulse, debounced button and period result bundle.
interface tap_period_if #(parameter int CNT_W = 19) ();
  logic             tp_i;
  logic             btn_i;
  logic [CNT_W-1:0] period_o;
  logic             period_valid_o;
  logic             active_o;
  modport master (output tp_i, btn_i, input period_o, period_valid_o, active_o);
  modport slave (input tp_i, btn_i, output period_o, period_valid_o, active_o);
endinterface

// File: rtl/tap_period_history.sv
// tap_history: four-entry interval history with seed/push controls and a running sum.
module tap_history
  import tap_tempo_pkg::*;
#(
  parameter int CNT_W = 19,
  parameter int SUM_W = CNT_W + 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [CNT_W-1:0] cap_i,
  output logic [SUM_W-1:0] sum_o,
  output logic             seeded_o
);
  logic [3:0][CNT_W-1:0] h_q, h_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic seeded_q, seeded_d;
  always_comb begin
    h_d = h_q;
    sum_d = sum_q;
    seeded_d = seeded_q;
    if (push_i && !seeded_q) begin
      h_d = {4{cap_i}};
      sum_d = SUM_W'(cap_i) << 2;
      seeded_d = 1'b1;
    end else if (push_i) begin
      h_d = {h_q[2:0], cap_i};
      sum_d = sum_q + SUM_W'(cap_i) - SUM_W'(h_q[3]);
    end else if (clr_i) begin
      seeded_d = 1'b0;
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      sum_q <= '0;
      seeded_q <= 1'b0;
    end else begin
      h_q <= h_d;
      sum_q <= sum_d;
      seeded_q <= seeded_d;
    end
  end
  assign sum_o = sum_q;
  assign seeded_o = seeded_q;
endmodule

// File: rtl/tap_period.sv
// tap_period: measures spacing of debounced taps and presents the mean of the last four.
module tap_period
  import tap_tempo_pkg::*;
#(
  parameter int PULSE_PER_NS   = PULSE_PER_NS_DEF,
  parameter int TIMEOUT_PER_NS = 2_000_000_000,
  parameter int MIN_PER_NS     = 240_000_000
) (
  input logic        clk_i,
  input logic        rst_i,
  tap_period_if.slave bus
);
  localparam int MAX_COUNT = ns_to_count(TIMEOUT_PER_NS, PULSE_PER_NS);
  localparam int MIN_COUNT = ns_to_count(MIN_PER_NS, PULSE_PER_NS);
  localparam int CNT_W = $clog2(MAX_COUNT + 1);
  localparam int SUM_W = CNT_W + 2;
  logic [0:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cap, period_q, period_d;
  logic btn_q, btn_d, acc_q, acc_d, valid_q, valid_d;
  logic rise, timeout, accept, clr, seeded;
  logic [SUM_W-1:0] sum;
  always_comb begin
    rise = bus.btn_i & ~btn_q;
    cap = cnt_q + CNT_W'(bus.tp_i);
    timeout = (state_q == s_count) && (cnt_q == CNT_W'(MAX_COUNT));
    accept = (state_q == s_count) && !timeout && rise && (cap >= CNT_W'(MIN_COUNT));
    clr = (state_q == s_idle) || timeout;
    // a rise during timeout restarts counting as a fresh first tap
    state_d = (clr && !rise) ? s_idle : s_count;
    cnt_d = (clr || accept) ? '0 : cap;
    btn_d = bus.btn_i;
    acc_d = accept;
    valid_d = acc_q & seeded;
    period_d = valid_d ? CNT_W'(sum >> 2) : period_q;
  end
  tap_history #(.CNT_W(CNT_W), .SUM_W(SUM_W)) u_hist (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr),
    .push_i  (accept),
    .cap_i   (cap),
    .sum_o   (sum),
    .seeded_o(seeded)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= s_idle;
      cnt_q <= '0;
      btn_q <= 1'b0;
      acc_q <= 1'b0;
      valid_q <= 1'b0;
      period_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      btn_q <= btn_d;
      acc_q <= acc_d;
      valid_q <= valid_d;
      period_q <= period_d;
    end
  end
  assign bus.period_o = period_q;
  assign bus.period_valid_o = valid_q;
  assign bus.active_o = (state_q == s_count);
endmodule
